adc083000_pair_aligner: RTL

- Downstream consumer of the ADC083000 demux interface, clocked by its read-side ctrl_clk_out.
- Receives the two half-rate FIFO streams: half0 carries samples 0-3 and half1 carries samples 4-7, each with its own valid.
- Pairs each half0 with the following half1 into one 8-sample I word and one 8-sample Q word per output beat.
- Detects and counts pairing faults, and reports a stream-lock status to the user design.

---
 rtl/adc083000_pair_aligner.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/adc083000_pair_aligner.sv
// Pairs the ADC083000 half0 (samples 0-3) and half1 (samples 4-7) FIFO words into
// 8-sample I/Q beats, flags pairing faults, and tracks stream lock.
module adc083000_pair_aligner #(
    parameter int TIMEOUT    = 4,
    parameter int ERR_W      = 16,
    parameter int LOCK_PAIRS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [63:0]      in_data0,
    input  logic             in_valid0,
    input  logic [63:0]      in_data1,
    input  logic             in_valid1,
    output logic [63:0]      out_i,
    output logic [63:0]      out_q,
    output logic             out_valid,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [ERR_W-1:0] err_count,
    output logic             locked
);

    typedef enum logic {
        IDLE,
        WAIT1
    } state_t;

    typedef enum logic [1:0] {
        CODE_NONE    = 2'b00,
        CODE_ORPHAN  = 2'b01,
        CODE_OVERRUN = 2'b10,
        CODE_TIMEOUT = 2'b11
    } code_t;

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int GOOD_W = $clog2(LOCK_PAIRS + 1);

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [GOOD_W-1:0] GOOD_MAX  = GOOD_W'(LOCK_PAIRS);
    localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

    state_t            state, state_next;
    logic [63:0]       hold, hold_next;
    logic [WAIT_W-1:0] wait_cnt, wait_next;
    logic [GOOD_W-1:0] good_cnt, good_next;

    logic        emit;
    logic [63:0] pair_lo;
    logic        fault;
    code_t       code;

    // NOTE: every signal this block writes gets a default first, otherwise a path
    // that skips an assignment makes synthesis infer a latch.
    always_comb begin
        state_next = state;
        hold_next  = hold;
        wait_next  = wait_cnt;
        emit       = 1'b0;
        pair_lo    = hold;
        fault      = 1'b0;
        code       = CODE_NONE;

        unique case (state)
            IDLE: begin
                if (in_valid0 && in_valid1) begin
                    emit    = 1'b1;
                    pair_lo = in_data0;
                end else if (in_valid0) begin
                    hold_next  = in_data0;
                    wait_next  = '0;
                    state_next = WAIT1;
                end else if (in_valid1) begin
                    fault = 1'b1;
                    code  = CODE_ORPHAN;
                end
            end

            WAIT1: begin
                if (in_valid1) begin
                    emit = 1'b1;
                    if (in_valid0) begin
                        hold_next = in_data0;
                        wait_next = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (in_valid0) begin
                    // Overrun wins over a timeout landing in the same cycle.
                    fault     = 1'b1;
                    code      = CODE_OVERRUN;
                    hold_next = in_data0;
                    wait_next = '0;
                end else if (wait_cnt == WAIT_LAST) begin
                    fault      = 1'b1;
                    code       = CODE_TIMEOUT;
                    hold_next  = '0;
                    wait_next  = '0;
                    state_next = IDLE;
                end else begin
                    wait_next = wait_cnt + 1'b1;
                end
            end

            default: state_next = IDLE;
        endcase

        if (fault) begin
            good_next = '0;
        end else if (emit && (good_cnt != GOOD_MAX)) begin
            good_next = good_cnt + 1'b1;
        end else begin
            good_next = good_cnt;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            hold     <= '0;
            wait_cnt <= '0;
            good_cnt <= '0;
        end else begin
            state    <= state_next;
            hold     <= hold_next;
            wait_cnt <= wait_next;
            good_cnt <= good_next;
        end
    end

    // Locked is taken from the next-state count so it moves with the out_valid/err pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_i     <= '0;
            out_q     <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
            err_code  <= CODE_NONE;
            err_count <= '0;
            locked    <= 1'b0;
        end else begin
            out_valid <= emit;
            err       <= fault;
            locked    <= (good_next == GOOD_MAX);
            if (emit) begin
                out_i <= {pair_lo[63:32], in_data1[63:32]};
                out_q <= {pair_lo[31:0],  in_data1[31:0]};
            end
            if (fault) begin
                err_code <= code;
                if (err_count != ERR_MAX) begin
                    err_count <= err_count + 1'b1;
                end
            end
        end
    end

endmodule
